// File: rtl/minimal_bus.sv
// minimal_bus: ASCII register bridge. Parses "M aaaa [dddd] CR LF" from a byte stream,
// reads/writes a local 16-bit register file and streams "M hhhh CR LF" read responses.
// Optional build macro LOWERCASE_HEX_EN: also accept 'a'-'f' digits and 'm' start byte.
module minimal_bus #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] BaseW  = 16'(BASE_ADDR);
  localparam logic [16:0] DepthW = 17'(DEPTH);

  localparam logic [7:0] ChCr = 8'h0D;
  localparam logic [7:0] ChLf = 8'h0A;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CR   = 3'd3;
  localparam logic [2:0] S_LF   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic        wr_q, wr_d;
  logic        req_q, req_d;
  logic        req_wr_q, req_wr_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [15:0] req_data_q, req_data_d;

  logic        is_hex, is_start;
  logic [3:0]  nib;

  logic [15:0] mem [DEPTH];
  logic [15:0] offset;
  logic        in_range;
  logic [AW-1:0] idx;
  logic        rd_valid_q;
  logic [15:0] rd_data_q;

  logic        active_q, active_d;
  logic [2:0]  bidx_q, bidx_d;
  logic [15:0] word_q, word_d;
  logic        pend_q, pend_d;
  logic [15:0] pend_word_q, pend_word_d;
  logic [7:0]  tx_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Classify the incoming byte: start marker and hex digit value.
  always_comb begin
    is_hex = 1'b1;
    nib    = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      nib = rx_data[3:0];
    end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
      nib = rx_data[3:0] + 4'd9;
`ifdef LOWERCASE_HEX_EN
    end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
      nib = rx_data[3:0] + 4'd9;
`endif
    end else begin
      is_hex = 1'b0;
    end
`ifdef LOWERCASE_HEX_EN
    is_start = (rx_data == 8'h4D) || (rx_data == 8'h6D);
`else
    is_start = (rx_data == 8'h4D);
`endif
  end

  // Parser next state: collect 4 address digits, optional 4 data digits, then CR LF.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    wr_d       = wr_q;
    req_d      = 1'b0;
    req_wr_d   = req_wr_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    if (rx_valid) begin
      if (is_start) begin
        state_d = S_ADDR;
        cnt_d   = 2'd0;
      end else begin
        case (state_q)
          S_ADDR: begin
            if (is_hex) begin
              shreg_d = {shreg_q[27:0], nib};
              cnt_d   = cnt_q + 2'd1;
              if (cnt_q == 2'd3) state_d = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end
          S_DATA: begin
            if (is_hex) begin
              shreg_d = {shreg_q[27:0], nib};
              cnt_d   = cnt_q + 2'd1;
              if (cnt_q == 2'd3) state_d = S_CR;
            end else if (rx_data == ChCr && cnt_q == 2'd0) begin
              state_d = S_LF;
              wr_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end
          S_CR: begin
            state_d = (rx_data == ChCr) ? S_LF : S_IDLE;
            wr_d    = 1'b1;
          end
          S_LF: begin
            state_d = S_IDLE;
            if (rx_data == ChLf) begin
              req_d      = 1'b1;
              req_wr_d   = wr_q;
              req_addr_d = wr_q ? shreg_q[31:16] : shreg_q[15:0];
              req_data_d = shreg_q[15:0];
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Parser and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      shreg_q    <= 32'h0;
      wr_q       <= 1'b0;
      req_q      <= 1'b0;
      req_wr_q   <= 1'b0;
      req_addr_q <= 16'h0;
      req_data_q <= 16'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      wr_q       <= wr_d;
      req_q      <= req_d;
      req_wr_q   <= req_wr_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
    end
  end

  // Range check without wraparound: address below the base is simply out of range.
  always_comb begin
    offset   = req_addr_q - BaseW;
    in_range = (req_addr_q >= BaseW) && ({1'b0, offset} < DepthW);
    idx      = offset[AW-1:0];
  end

  // Register file storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (req_q && req_wr_q && in_range) mem[idx] <= req_data_q;
  end

  // Registered read result; out-of-range reads return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= 16'h0;
    end else begin
      rd_valid_q <= req_q && !req_wr_q;
      if (req_q && !req_wr_q) rd_data_q <= in_range ? mem[idx] : 16'h0;
    end
  end

  // Formatter next state: advance on handshake, refill from the pending slot, queue reads.
  always_comb begin
    active_d    = active_q;
    bidx_d      = bidx_q;
    word_d      = word_q;
    pend_d      = pend_q;
    pend_word_d = pend_word_q;
    if (active_q && tx_ready) begin
      if (bidx_q == 3'd6) begin
        if (pend_q) begin
          word_d = pend_word_q;
          bidx_d = 3'd0;
          pend_d = 1'b0;
        end else begin
          active_d = 1'b0;
        end
      end else begin
        bidx_d = bidx_q + 3'd1;
      end
    end
    if (rd_valid_q) begin
      if (!active_d) begin
        active_d = 1'b1;
        word_d   = rd_data_q;
        bidx_d   = 3'd0;
      end else if (!pend_d) begin
        pend_d      = 1'b1;
        pend_word_d = rd_data_q;
      end
    end
  end

  // Formatter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q    <= 1'b0;
      bidx_q      <= 3'd0;
      word_q      <= 16'h0;
      pend_q      <= 1'b0;
      pend_word_q <= 16'h0;
    end else begin
      active_q    <= active_d;
      bidx_q      <= bidx_d;
      word_q      <= word_d;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
    end
  end

  // Select the response byte for the current position.
  always_comb begin
    case (bidx_q)
      3'd0:    tx_byte = 8'h4D;
      3'd1:    tx_byte = hex_char(word_q[15:12]);
      3'd2:    tx_byte = hex_char(word_q[11:8]);
      3'd3:    tx_byte = hex_char(word_q[7:4]);
      3'd4:    tx_byte = hex_char(word_q[3:0]);
      3'd5:    tx_byte = ChCr;
      3'd6:    tx_byte = ChLf;
      default: tx_byte = 8'h00;
    endcase
    tx_valid = active_q;
    tx_data  = active_q ? tx_byte : 8'h00;
  end

endmodule

// File: tb/tb_minimal_bus.sv
// Directed bench for minimal_bus: command parsing, register access and response streaming.
module tb_minimal_bus;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [7:0]  q[$];
  logic        ready_rand = 1'b0;
  logic        prev_low;
  logic        stall_prev = 1'b0;
  logic [7:0]  data_prev  = 8'h00;

  minimal_bus #(.DEPTH(32), .BASE_ADDR(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ready driver: random stalls never longer than one cycle when enabled.
  initial begin
    tx_ready = 1'b1;
    prev_low = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_rand && !prev_low) tx_ready = ($urandom_range(0, 2) != 0);
      else tx_ready = 1'b1;
      prev_low = !tx_ready;
    end
  end

  // Capture transferred bytes and check data is held while stalled.
  always @(negedge clk) begin
    if (!rst && stall_prev && tx_valid) check("hold", {24'h0, tx_data}, {24'h0, data_prev});
    if (!rst && tx_valid && tx_ready) q.push_back(tx_data);
    stall_prev = !rst && tx_valid && !tx_ready;
    data_prev  = tx_data;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_read(input logic [15:0] a);
    send_byte(8'h4D);
    for (int i = 3; i >= 0; i--) send_byte(hexc(a[i*4 +: 4]));
    send_byte(8'h0D);
    send_byte(8'h0A);
  endtask

  task automatic send_write(input logic [15:0] a, input logic [15:0] d);
    send_byte(8'h4D);
    for (int i = 3; i >= 0; i--) send_byte(hexc(a[i*4 +: 4]));
    for (int i = 3; i >= 0; i--) send_byte(hexc(d[i*4 +: 4]));
    send_byte(8'h0D);
    send_byte(8'h0A);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    for (int i = 0; i < budget && q.size() < n; i++) @(posedge clk);
    #2;
    check("byte_count", q.size(), n);
  endtask

  // Pop one 7-byte response and compare with the expected text.
  task automatic pop_resp(input string tag, input logic [15:0] v);
    logic [7:0] exp [7];
    exp[0] = 8'h4D;
    exp[1] = hexc(v[15:12]);
    exp[2] = hexc(v[11:8]);
    exp[3] = hexc(v[7:4]);
    exp[4] = hexc(v[3:0]);
    exp[5] = 8'h0D;
    exp[6] = 8'h0A;
    for (int i = 0; i < 7; i++) begin
      if (q.size() > 0) check(tag, {24'h0, q.pop_front()}, {24'h0, exp[i]});
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) dut.mem[i] = 16'(i);

    // 1: plain read
    send_read(16'h0005);
    wait_bytes(7, 100);
    pop_resp("read5", 16'h0005);

    // 2: write produces nothing, read back
    send_write(16'h0003, 16'h1234);
    repeat (20) @(posedge clk);
    check("write_silent", q.size(), 0);
    send_read(16'h0003);
    wait_bytes(7, 100);
    pop_resp("read3", 16'h1234);

    // 3: out-of-range read and write
    send_read(16'h1234);
    wait_bytes(7, 100);
    pop_resp("read_oor", 16'h0000);
    send_write(16'h1234, 16'h5678);
    repeat (10) @(posedge clk);
    send_read(16'h0014);
    wait_bytes(7, 100);
    pop_resp("alias_unchanged", 16'h0014);

    // 4: invalid digit aborts; trailing bytes ignored in idle
    send_byte(8'h4D);
    send_byte(8'h30);
    send_byte(8'h47);
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h0D);
    send_byte(8'h0A);
    repeat (20) @(posedge clk);
    check("bad_digit_silent", q.size(), 0);
    send_read(16'h0001);
    wait_bytes(7, 100);
    pop_resp("read1", 16'h0001);

    // 5: back-to-back reads under random stalls
    ready_rand = 1'b1;
    for (int i = 0; i < 32; i++) send_read(16'(i));
    wait_bytes(32 * 7, 3000);
    for (int i = 0; i < 32; i++) pop_resp("burst", (i == 3) ? 16'h1234 : 16'(i));
    ready_rand = 1'b0;
    repeat (4) @(posedge clk);

    // 6: reset while a response is in flight
    send_read(16'h0009);
    for (int i = 0; i < 100 && q.size() < 3; i++) begin
      @(posedge clk);
      #2;
    end
    check("pre_reset_bytes", q.size(), 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("reset_tx_data", {24'h0, tx_data}, 32'h0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    check("no_bytes_after_reset", q.size(), 3);
    q.delete();
    send_read(16'h0007);
    wait_bytes(7, 100);
    pop_resp("read7_after_reset", 16'h0007);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
